// File: rtl/id_ex_register.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_register
// Description : Decode-to-Execute pipeline register with load-use hazard
//               detection. Captures the decoded ID instruction (control, operands,
//               immediate, register indices, PC+4) and presents it to EX one
//               cycle later. If a load in EX writes a register that the ID
//               instruction reads, load_use_stall is raised combinationally and
//               a bubble is inserted at the next edge. A flush (taken branch)
//               squashes the ID instruction and overrides the stall.
// Config      : ID_EX_BUBBLE_CNT_EN - when defined, bubble_count is a
//               saturating CNT_WIDTH counter of load-use bubbles; when
//               undefined, bubble_count is tied to 0 (same port list).
// Ports       : clk, reset (async, active-low)
//               valid_in / flush_in / uses_rt_in : ID status
//               *_in  -> *_out  : control, data, indices, registered copies
//               valid_out       : EX holds a real instruction
//               load_use_stall  : combinational, hold PC and IF/ID
//               bubble_count    : load-use bubbles since reset
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_register #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int ALU_OP_WIDTH   = 4,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      valid_in,
   input  logic                      flush_in,
   input  logic                      uses_rt_in,
   input  logic                      reg_write_in,
   input  logic [1:0]                mem_to_reg_in,
   input  logic                      mem_write_in,
   input  logic                      mem_read_in,
   input  logic                      branch_ne_in,
   input  logic                      branch_eq_in,
   input  logic                      alu_src_in,
   input  logic                      reg_dst_in,
   input  logic [ALU_OP_WIDTH-1:0]   alu_op_in,
   input  logic [DATA_WIDTH-1:0]     read_data_1_in,
   input  logic [DATA_WIDTH-1:0]     read_data_2_in,
   input  logic [DATA_WIDTH-1:0]     imm_ext_in,
   input  logic [DATA_WIDTH-1:0]     pc_plus4_in,
   input  logic [REG_ADDR_WIDTH-1:0] rs_in,
   input  logic [REG_ADDR_WIDTH-1:0] rt_in,
   input  logic [REG_ADDR_WIDTH-1:0] rd_in,
   output logic                      reg_write_out,
   output logic [1:0]                mem_to_reg_out,
   output logic                      mem_write_out,
   output logic                      mem_read_out,
   output logic                      branch_ne_out,
   output logic                      branch_eq_out,
   output logic                      alu_src_out,
   output logic                      reg_dst_out,
   output logic [ALU_OP_WIDTH-1:0]   alu_op_out,
   output logic [DATA_WIDTH-1:0]     read_data_1_out,
   output logic [DATA_WIDTH-1:0]     read_data_2_out,
   output logic [DATA_WIDTH-1:0]     imm_ext_out,
   output logic [DATA_WIDTH-1:0]     pc_plus4_out,
   output logic [REG_ADDR_WIDTH-1:0] rs_out,
   output logic [REG_ADDR_WIDTH-1:0] rt_out,
   output logic [REG_ADDR_WIDTH-1:0] rd_out,
   output logic                      valid_out,
   output logic                      load_use_stall,
   output logic [CNT_WIDTH-1:0]      bubble_count
);

   // Pipeline register state
   logic                      valid_q,     valid_d;
   logic                      reg_write_q, reg_write_d;
   logic [1:0]                mem_to_reg_q, mem_to_reg_d;
   logic                      mem_write_q, mem_write_d;
   logic                      mem_read_q,  mem_read_d;
   logic                      branch_ne_q, branch_ne_d;
   logic                      branch_eq_q, branch_eq_d;
   logic                      alu_src_q,   alu_src_d;
   logic                      reg_dst_q,   reg_dst_d;
   logic [ALU_OP_WIDTH-1:0]   alu_op_q,    alu_op_d;
   logic [DATA_WIDTH-1:0]     rd1_q,       rd1_d;
   logic [DATA_WIDTH-1:0]     rd2_q,       rd2_d;
   logic [DATA_WIDTH-1:0]     imm_q,       imm_d;
   logic [DATA_WIDTH-1:0]     pc4_q,       pc4_d;
   logic [REG_ADDR_WIDTH-1:0] rs_q,        rs_d;
   logic [REG_ADDR_WIDTH-1:0] rt_q,        rt_d;
   logic [REG_ADDR_WIDTH-1:0] rd_q,        rd_d;

   logic w_hit;
   logic w_stall;
   logic w_bubble;

   // Hazard: a valid load in EX whose destination (rt) is a source of the
   // valid ID instruction. Register 0 is hardwired, so it never forwards a hazard.
   always_comb begin
      w_hit = valid_q & mem_read_q & (rt_q != '0) & valid_in &
              ((rt_q == rs_in) | (uses_rt_in & (rt_q == rt_in)));
      // A flushed ID instruction is discarded, so there is nothing to stall for.
      w_stall  = w_hit & ~flush_in;
      w_bubble = flush_in | w_stall;
   end

   assign load_use_stall = w_stall;

   // Next state: either capture ID or insert an all-zero bubble
   always_comb begin
      valid_d      = valid_in;
      reg_write_d  = reg_write_in;
      mem_to_reg_d = mem_to_reg_in;
      mem_write_d  = mem_write_in;
      mem_read_d   = mem_read_in;
      branch_ne_d  = branch_ne_in;
      branch_eq_d  = branch_eq_in;
      alu_src_d    = alu_src_in;
      reg_dst_d    = reg_dst_in;
      alu_op_d     = alu_op_in;
      rd1_d        = read_data_1_in;
      rd2_d        = read_data_2_in;
      imm_d        = imm_ext_in;
      pc4_d        = pc_plus4_in;
      rs_d         = rs_in;
      rt_d         = rt_in;
      rd_d         = rd_in;
      if (w_bubble) begin
         valid_d      = 1'b0;
         reg_write_d  = 1'b0;
         mem_to_reg_d = '0;
         mem_write_d  = 1'b0;
         mem_read_d   = 1'b0;
         branch_ne_d  = 1'b0;
         branch_eq_d  = 1'b0;
         alu_src_d    = 1'b0;
         reg_dst_d    = 1'b0;
         alu_op_d     = '0;
         rd1_d        = '0;
         rd2_d        = '0;
         imm_d        = '0;
         pc4_d        = '0;
         rs_d         = '0;
         rt_d         = '0;
         rd_d         = '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q      <= 1'b0;
         reg_write_q  <= 1'b0;
         mem_to_reg_q <= '0;
         mem_write_q  <= 1'b0;
         mem_read_q   <= 1'b0;
         branch_ne_q  <= 1'b0;
         branch_eq_q  <= 1'b0;
         alu_src_q    <= 1'b0;
         reg_dst_q    <= 1'b0;
         alu_op_q     <= '0;
         rd1_q        <= '0;
         rd2_q        <= '0;
         imm_q        <= '0;
         pc4_q        <= '0;
         rs_q         <= '0;
         rt_q         <= '0;
         rd_q         <= '0;
      end else begin
         valid_q      <= valid_d;
         reg_write_q  <= reg_write_d;
         mem_to_reg_q <= mem_to_reg_d;
         mem_write_q  <= mem_write_d;
         mem_read_q   <= mem_read_d;
         branch_ne_q  <= branch_ne_d;
         branch_eq_q  <= branch_eq_d;
         alu_src_q    <= alu_src_d;
         reg_dst_q    <= reg_dst_d;
         alu_op_q     <= alu_op_d;
         rd1_q        <= rd1_d;
         rd2_q        <= rd2_d;
         imm_q        <= imm_d;
         pc4_q        <= pc4_d;
         rs_q         <= rs_d;
         rt_q         <= rt_d;
         rd_q         <= rd_d;
      end
   end

   assign valid_out       = valid_q;
   assign reg_write_out   = reg_write_q;
   assign mem_to_reg_out  = mem_to_reg_q;
   assign mem_write_out   = mem_write_q;
   assign mem_read_out    = mem_read_q;
   assign branch_ne_out   = branch_ne_q;
   assign branch_eq_out   = branch_eq_q;
   assign alu_src_out     = alu_src_q;
   assign reg_dst_out     = reg_dst_q;
   assign alu_op_out      = alu_op_q;
   assign read_data_1_out = rd1_q;
   assign read_data_2_out = rd2_q;
   assign imm_ext_out     = imm_q;
   assign pc_plus4_out    = pc4_q;
   assign rs_out          = rs_q;
   assign rt_out          = rt_q;
   assign rd_out          = rd_q;

`ifdef ID_EX_BUBBLE_CNT_EN
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

   // Only load-use bubbles are counted; holds at all-ones instead of wrapping.
   always_comb begin
      cnt_d = cnt_q;
      if (w_stall && (cnt_q != {CNT_WIDTH{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign bubble_count = cnt_q;
`else
   assign bubble_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_id_ex_register.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_register
// Description : Self-checking bench for id_ex_register. Directed scenarios plus
//               randomized traffic compared against a behavioural model of the
//               pipeline stage (EX contents, hazard rule, bubble counter).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_register;

   localparam int C_CNT_WIDTH = 2;
   localparam int C_CNT_MAX   = 3;
`ifdef ID_EX_BUBBLE_CNT_EN
   localparam bit C_CNT_EN = 1'b1;
`else
   localparam bit C_CNT_EN = 1'b0;
`endif

   typedef struct packed {
      logic        reg_write;
      logic [1:0]  mem_to_reg;
      logic        mem_write;
      logic        mem_read;
      logic        branch_ne;
      logic        branch_eq;
      logic        alu_src;
      logic        reg_dst;
      logic [3:0]  alu_op;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] imm;
      logic [31:0] pc4;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
   } fields_t;

   logic    clk;
   logic    reset;
   logic    valid_in;
   logic    flush_in;
   logic    uses_rt_in;
   fields_t in_f;
   fields_t out_f;

   logic                   reg_write_out, mem_write_out, mem_read_out;
   logic                   branch_ne_out, branch_eq_out, alu_src_out, reg_dst_out;
   logic [1:0]             mem_to_reg_out;
   logic [3:0]             alu_op_out;
   logic [31:0]            read_data_1_out, read_data_2_out, imm_ext_out, pc_plus4_out;
   logic [4:0]             rs_out, rt_out, rd_out;
   logic                   valid_out;
   logic                   load_use_stall;
   logic [C_CNT_WIDTH-1:0] bubble_count;

   id_ex_register #(
      .DATA_WIDTH    (32),
      .REG_ADDR_WIDTH(5),
      .ALU_OP_WIDTH  (4),
      .CNT_WIDTH     (C_CNT_WIDTH)
   ) u_dut (
      .clk            (clk),
      .reset          (reset),
      .valid_in       (valid_in),
      .flush_in       (flush_in),
      .uses_rt_in     (uses_rt_in),
      .reg_write_in   (in_f.reg_write),
      .mem_to_reg_in  (in_f.mem_to_reg),
      .mem_write_in   (in_f.mem_write),
      .mem_read_in    (in_f.mem_read),
      .branch_ne_in   (in_f.branch_ne),
      .branch_eq_in   (in_f.branch_eq),
      .alu_src_in     (in_f.alu_src),
      .reg_dst_in     (in_f.reg_dst),
      .alu_op_in      (in_f.alu_op),
      .read_data_1_in (in_f.rd1),
      .read_data_2_in (in_f.rd2),
      .imm_ext_in     (in_f.imm),
      .pc_plus4_in    (in_f.pc4),
      .rs_in          (in_f.rs),
      .rt_in          (in_f.rt),
      .rd_in          (in_f.rd),
      .reg_write_out  (reg_write_out),
      .mem_to_reg_out (mem_to_reg_out),
      .mem_write_out  (mem_write_out),
      .mem_read_out   (mem_read_out),
      .branch_ne_out  (branch_ne_out),
      .branch_eq_out  (branch_eq_out),
      .alu_src_out    (alu_src_out),
      .reg_dst_out    (reg_dst_out),
      .alu_op_out     (alu_op_out),
      .read_data_1_out(read_data_1_out),
      .read_data_2_out(read_data_2_out),
      .imm_ext_out    (imm_ext_out),
      .pc_plus4_out   (pc_plus4_out),
      .rs_out         (rs_out),
      .rt_out         (rt_out),
      .rd_out         (rd_out),
      .valid_out      (valid_out),
      .load_use_stall (load_use_stall),
      .bubble_count   (bubble_count)
   );

   assign out_f = {reg_write_out, mem_to_reg_out, mem_write_out, mem_read_out,
                   branch_ne_out, branch_eq_out, alu_src_out, reg_dst_out,
                   alu_op_out, read_data_1_out, read_data_2_out, imm_ext_out,
                   pc_plus4_out, rs_out, rt_out, rd_out};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: what EX should hold, and how many bubbles were counted
   fields_t exp_f;
   logic    exp_v;
   int      exp_cnt;
   logic    obs_stall;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic model_reset();
      exp_f   = '0;
      exp_v   = 1'b0;
      exp_cnt = 0;
   endtask

   // Called just after a negedge: drive ID, check stall, advance one edge, check EX
   task automatic step(input fields_t f, input logic v, input logic fl, input logic ur);
      logic hit;
      logic st;
      in_f       = f;
      valid_in   = v;
      flush_in   = fl;
      uses_rt_in = ur;
      #1;
      hit = exp_v && exp_f.mem_read && (exp_f.rt != 5'd0) && v &&
            ((exp_f.rt == f.rs) || (ur && (exp_f.rt == f.rt)));
      st  = hit && !fl;
      obs_stall = load_use_stall;
      check("stall", load_use_stall, st);
      @(posedge clk);
      if (fl || st) begin
         exp_f = '0;
         exp_v = 1'b0;
      end else begin
         exp_f = f;
         exp_v = v;
      end
      if (st && C_CNT_EN && exp_cnt < C_CNT_MAX) exp_cnt++;
      @(negedge clk);
      check("fields", out_f, exp_f);
      check("valid", valid_out, exp_v);
      check("count", bubble_count, exp_cnt);
   endtask

   function automatic fields_t rand_fields();
      fields_t f;
      f.reg_write  = 1'($urandom);
      f.mem_to_reg = 2'($urandom);
      f.mem_write  = 1'($urandom);
      f.mem_read   = ($urandom_range(0, 1) == 0);
      f.branch_ne  = 1'($urandom);
      f.branch_eq  = 1'($urandom);
      f.alu_src    = 1'($urandom);
      f.reg_dst    = 1'($urandom);
      f.alu_op     = 4'($urandom);
      f.rd1        = $urandom;
      f.rd2        = $urandom;
      f.imm        = $urandom;
      f.pc4        = $urandom;
      f.rs         = 5'($urandom_range(0, 3));
      f.rt         = 5'($urandom_range(0, 3));
      f.rd         = 5'($urandom);
      return f;
   endfunction

   fields_t lw_f;
   fields_t dep_f;
   fields_t f;

   initial begin
      reset      = 1'b0;
      valid_in   = 1'b0;
      flush_in   = 1'b0;
      uses_rt_in = 1'b0;
      in_f       = '0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_fields", out_f, '0);
      check("rst_valid", valid_out, 1'b0);
      check("rst_count", bubble_count, '0);
      check("rst_stall", load_use_stall, 1'b0);
      reset = 1'b1;

      // Pass-through
      f = '0;
      f.rd = 5'd5; f.alu_op = 4'h2; f.rd1 = 32'hDEADBEEF; f.imm = 32'hFFFF_FFFC;
      step(f, 1'b1, 1'b0, 1'b0);
      check("pt_rd", rd_out, 5'd5);
      check("pt_aluop", alu_op_out, 4'h2);
      check("pt_rd1", read_data_1_out, 32'hDEADBEEF);
      check("pt_imm", imm_ext_out, 32'hFFFF_FFFC);
      check("pt_valid", valid_out, 1'b1);
      check("pt_stall", load_use_stall, 1'b0);

      // Load-use on rs
      lw_f = '0; lw_f.mem_read = 1'b1; lw_f.reg_write = 1'b1; lw_f.rt = 5'd8; lw_f.rs = 5'd1;
      dep_f = '0; dep_f.reg_write = 1'b1; dep_f.rs = 5'd8; dep_f.rt = 5'd2; dep_f.rd = 5'd3;
      step(lw_f, 1'b1, 1'b0, 1'b0);
      step(dep_f, 1'b1, 1'b0, 1'b0);
      check("lu_stall", obs_stall, 1'b1);
      check("lu_bub_valid", valid_out, 1'b0);
      check("lu_bub_rw", reg_write_out, 1'b0);
      check("lu_stall_drop", load_use_stall, 1'b0);
      step(dep_f, 1'b1, 1'b0, 1'b0);
      check("lu_capture_rs", rs_out, 5'd8);
      check("lu_count", bubble_count, C_CNT_EN ? 2'd1 : 2'd0);

      // No false hazard: rt_out==0
      lw_f.rt = 5'd0;
      step(lw_f, 1'b1, 1'b0, 1'b0);
      dep_f.rs = 5'd0;
      step(dep_f, 1'b1, 1'b0, 1'b1);
      check("nf_r0", obs_stall, 1'b0);
      // No false hazard: rt matches but rt not used
      lw_f.rt = 5'd9;
      step(lw_f, 1'b1, 1'b0, 1'b0);
      dep_f.rs = 5'd1; dep_f.rt = 5'd9;
      step(dep_f, 1'b1, 1'b0, 1'b0);
      check("nf_uses_rt", obs_stall, 1'b0);

      // Flush overrides hazard
      step(lw_f, 1'b1, 1'b0, 1'b0);
      step(dep_f, 1'b1, 1'b1, 1'b1);
      check("fl_stall", obs_stall, 1'b0);
      check("fl_valid", valid_out, 1'b0);
      check("fl_count", bubble_count, C_CNT_EN ? 2'd1 : 2'd0);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         step(rand_fields(), ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
              1'($urandom));
      end

      // Reset mid-stream, asynchronous
      f = rand_fields();
      f.rd = 5'd7; f.reg_write = 1'b1; f.imm = 32'h1234_5678;
      step(f, 1'b1, 1'b0, 1'b0);
      step(f, 1'b1, 1'b0, 1'b0);
      #2 reset = 1'b0;
      #1;
      model_reset();
      check("ar_fields", out_f, '0);
      check("ar_valid", valid_out, 1'b0);
      check("ar_count", bubble_count, '0);
      check("ar_stall", load_use_stall, 1'b0);
      @(posedge clk);
      #1 check("ar_hold", out_f, '0);
      @(negedge clk);
      reset = 1'b1;

      // Saturation: five load-use bubbles
      lw_f = '0; lw_f.mem_read = 1'b1; lw_f.rt = 5'd8;
      dep_f = '0; dep_f.rs = 5'd8; dep_f.rd = 5'd4;
      for (int k = 0; k < 5; k++) begin
         logic [1:0] want;
         want = (k < 3) ? 2'(k + 1) : 2'd3;
         step(lw_f, 1'b1, 1'b0, 1'b0);
         step(dep_f, 1'b1, 1'b0, 1'b0);
         check("sat_count", bubble_count, C_CNT_EN ? want : 2'd0);
         step(dep_f, 1'b1, 1'b0, 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
